// File: rtl/gerador_pb_pkg.sv
// Shared definitions for the push-button generator and its decoder.
// The GERADOR_PB_BOUNCE_EN macro adds the contact-bounce states.
package pb_pkg;

  localparam int CNT_W                 = 16;
  localparam int DEBOUNCE_P_DEF        = 300;
  localparam int SWITCH_MODE_MIN_T_DEF = 5000;
  localparam int SHORT_HOLD_DEF        = 1000;
  localparam int LONG_HOLD_DEF         = 6000;
  localparam int GAP_T_DEF             = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_END
`ifdef GERADOR_PB_BOUNCE_EN
    , ST_BOUNCE_ON,
    ST_BOUNCE_OFF
`endif
  } pb_gen_state_t;

endpackage

// File: rtl/gerador_pb_timer.sv
// 16-bit loadable down-counter shared by hold, gap and bounce timing.
module pb_timer
  import pb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/gerador_pb.sv
// Push-button waveform generator: short (req_b) or long (req_a) press, then a guard gap.
// Define GERADOR_PB_BOUNCE_EN to emulate contact bounce around each edge of the press.
module gerador_pb
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_P        = DEBOUNCE_P_DEF,
  parameter int SWITCH_MODE_MIN_T = SWITCH_MODE_MIN_T_DEF,
  parameter int SHORT_HOLD        = SHORT_HOLD_DEF,
  parameter int LONG_HOLD         = LONG_HOLD_DEF,
  parameter int GAP_T             = GAP_T_DEF
`ifdef GERADOR_PB_BOUNCE_EN
  ,
  parameter int BOUNCE_CYC        = 8,
  parameter int BOUNCE_N          = 6
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  output logic          pb,
  output logic          busy,
  output logic          done,
  output logic          drop,
  output pb_gen_state_t o_dbg_state
);

  // The generated press must land firmly on the intended side of the decoder's thresholds.
  if (!(SHORT_HOLD < 65536 && LONG_HOLD < 65536 && GAP_T < 65536)) begin : g_chk_range
    $error("gerador_pb: times must fit the 16-bit counter");
  end
  if (!(DEBOUNCE_P + 3 < SHORT_HOLD && SHORT_HOLD < SWITCH_MODE_MIN_T)) begin : g_chk_short
    $error("gerador_pb: SHORT_HOLD outside decoder short window");
  end
  if (!(LONG_HOLD > SWITCH_MODE_MIN_T + DEBOUNCE_P + 3)) begin : g_chk_long
    $error("gerador_pb: LONG_HOLD too short for decoder long press");
  end
  if (!(GAP_T >= 4)) begin : g_chk_gap
    $error("gerador_pb: GAP_T must be at least 4");
  end
`ifdef GERADOR_PB_BOUNCE_EN
  if (!(BOUNCE_N * BOUNCE_CYC < DEBOUNCE_P && BOUNCE_N % 2 == 0 && BOUNCE_N > 0 && BOUNCE_N < 256))
  begin : g_chk_bounce
    $error("gerador_pb: bounce burst must be even and shorter than the decoder debounce");
  end
`endif

  pb_gen_state_t    r_state, w_next;
  logic             w_load, w_en, w_zero;
  logic [CNT_W-1:0] w_load_val;
  logic             w_req, w_pb_nxt, w_drop_nxt;
  logic             r_pb, r_busy, r_done, r_drop;
`ifdef GERADOR_PB_BOUNCE_EN
  logic             r_long, w_long_nxt;
  logic [7:0]       r_bcnt, w_bcnt_nxt;
`endif

  assign w_req = req_a | req_b;

  pb_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (w_en),
    .zero     (w_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_en       = 1'b0;
    w_drop_nxt = 1'b0;
`ifdef GERADOR_PB_BOUNCE_EN
    w_long_nxt = r_long;
    w_bcnt_nxt = r_bcnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_load = 1'b1;
`ifdef GERADOR_PB_BOUNCE_EN
          w_next     = ST_BOUNCE_ON;
          w_load_val = CNT_W'(BOUNCE_CYC - 1);
          w_long_nxt = req_a;
          w_bcnt_nxt = '0;
`else
          w_next     = ST_PRESS;
          w_load_val = req_a ? CNT_W'(LONG_HOLD - 1) : CNT_W'(SHORT_HOLD - 1);
`endif
        end
      end
`ifdef GERADOR_PB_BOUNCE_EN
      ST_BOUNCE_ON: begin
        w_drop_nxt = w_req;
        if (!w_zero) begin
          w_en = 1'b1;
        end else if (r_bcnt == 8'(BOUNCE_N - 1)) begin
          w_next     = ST_PRESS;
          w_load     = 1'b1;
          w_load_val = r_long ? CNT_W'(LONG_HOLD - 1) : CNT_W'(SHORT_HOLD - 1);
        end else begin
          w_load     = 1'b1;
          w_load_val = CNT_W'(BOUNCE_CYC - 1);
          w_bcnt_nxt = r_bcnt + 8'd1;
        end
      end
      ST_BOUNCE_OFF: begin
        w_drop_nxt = w_req;
        if (!w_zero) begin
          w_en = 1'b1;
        end else if (r_bcnt == 8'(BOUNCE_N - 1)) begin
          w_next     = ST_GAP;
          w_load     = 1'b1;
          w_load_val = CNT_W'(GAP_T - 1);
        end else begin
          w_load     = 1'b1;
          w_load_val = CNT_W'(BOUNCE_CYC - 1);
          w_bcnt_nxt = r_bcnt + 8'd1;
        end
      end
`endif
      ST_PRESS: begin
        w_drop_nxt = w_req;
        if (w_zero) begin
          w_load = 1'b1;
`ifdef GERADOR_PB_BOUNCE_EN
          w_next     = ST_BOUNCE_OFF;
          w_load_val = CNT_W'(BOUNCE_CYC - 1);
          w_bcnt_nxt = '0;
`else
          w_next     = ST_GAP;
          w_load_val = CNT_W'(GAP_T - 1);
`endif
        end else begin
          w_en = 1'b1;
        end
      end
      ST_GAP: begin
        w_drop_nxt = w_req;
        if (w_zero) w_next = ST_END;
        else        w_en   = 1'b1;
      end
      ST_END: begin
        w_drop_nxt = w_req;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // pb is registered from the next state so it changes on the same edge as the state.
  always_comb begin
    w_pb_nxt = 1'b0;
    case (w_next)
      ST_PRESS:      w_pb_nxt = 1'b1;
`ifdef GERADOR_PB_BOUNCE_EN
      ST_BOUNCE_ON:  w_pb_nxt = ~w_bcnt_nxt[0];
      ST_BOUNCE_OFF: w_pb_nxt = w_bcnt_nxt[0];
`endif
      default:       w_pb_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pb    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pb    <= w_pb_nxt;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_END);
      r_drop  <= w_drop_nxt;
    end
  end

`ifdef GERADOR_PB_BOUNCE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_long <= 1'b0;
      r_bcnt <= '0;
    end else begin
      r_long <= w_long_nxt;
      r_bcnt <= w_bcnt_nxt;
    end
  end
`endif

  assign pb          = r_pb;
  assign busy        = r_busy;
  assign done        = r_done;
  assign drop        = r_drop;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gerador_pb.sv
// Self-checking bench for gerador_pb (default build): press-window model plus directed literal checks.
module tb_gerador_pb;
  import pb_pkg::*;

  localparam int SHORT = 1000;
  localparam int LONG  = 6000;
  localparam int GAP   = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          req_a = 1'b0;
  logic          req_b = 1'b0;
  logic          pb, busy, done, drop;
  pb_gen_state_t dbg_state;

  longint cyc   = 0;
  int     tests = 0;
  int     fails = 0;

  gerador_pb dut (
    .clk         (clk),
    .rst         (rst),
    .req_a       (req_a),
    .req_b       (req_b),
    .pb          (pb),
    .busy        (busy),
    .done        (done),
    .drop        (drop),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic at_edge(input longint n);
    while (cyc < n) @(negedge clk);
  endtask

  // Model: an accepted press at edge acc owns pb for h edges, busy up to edge bl,
  // done on edge bl; a fresh accept needs one idle edge after bl.
  longint acc = -100, bl = -100, h = 0;
  logic   dexp = 1'b0;
  logic   e_pb, e_busy, e_done, e_drop;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      acc = -100; bl = -100; h = 0; dexp = 1'b0;
    end else if ((req_a || req_b) && cyc >= bl + 2) begin
      acc  = cyc;
      h    = req_a ? LONG : SHORT;
      bl   = cyc + h + GAP;
      dexp = 1'b0;
    end else begin
      dexp = req_a || req_b;
    end
    e_pb   = rst && cyc >= acc && cyc < acc + h;
    e_busy = rst && cyc >= acc && cyc <= bl;
    e_done = rst && cyc == bl;
    e_drop = rst && dexp;
    #1;
    check("model_pb", pb, e_pb);
    check("model_busy", busy, e_busy);
    check("model_done", done, e_done);
    check("model_drop", drop, e_drop);
  end

  initial begin
    longint l0, s0, b0, r0;
    at_edge(3);
    check("reset_pb", pb, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_drop", drop, 1'b0);
    rst = 1'b1;

    // Short press accepted on edge 10
    at_edge(9);    req_b = 1'b1;
    at_edge(10);   req_b = 1'b0;
    check("short_accept_pb", pb, 1'b1);
    check("short_accept_busy", busy, 1'b1);
    at_edge(1009); check("short_last_high", pb, 1'b1);
    at_edge(1010); check("short_release", pb, 1'b0);
    at_edge(1025); check("short_no_early_done", done, 1'b0);
    at_edge(1026); check("short_done", done, 1'b1);
    check("short_busy_in_end", busy, 1'b1);
    at_edge(1027); check("short_idle", busy, 1'b0);

    // Long press
    l0 = 1100;
    at_edge(l0 - 1);    req_a = 1'b1;
    at_edge(l0);        req_a = 1'b0;
    check("long_accept", pb, 1'b1);
    at_edge(l0 + 5999); check("long_last_high", pb, 1'b1);
    at_edge(l0 + 6000); check("long_release", pb, 1'b0);
    at_edge(l0 + 6016); check("long_done", done, 1'b1);

    // Both requests together, then an extra request while busy
    s0 = 7200;
    at_edge(s0 - 1);    req_a = 1'b1; req_b = 1'b1;
    at_edge(s0);        req_a = 1'b0; req_b = 1'b0;
    check("simul_no_drop", drop, 1'b0);
    at_edge(s0 + 199);  req_b = 1'b1;
    at_edge(s0 + 200);  req_b = 1'b0;
    check("busy_req_drop", drop, 1'b1);
    check("busy_req_pb", pb, 1'b1);
    at_edge(s0 + 201);  check("drop_one_cycle", drop, 1'b0);
    at_edge(s0 + 1000); check("simul_is_long", pb, 1'b1);
    at_edge(s0 + 6016); check("simul_done", done, 1'b1);

    // Back-to-back: second request in the cycle IDLE is re-entered
    b0 = 13300;
    at_edge(b0 - 1);    req_b = 1'b1;
    at_edge(b0);        req_b = 1'b0;
    at_edge(b0 + 1017); check("b2b_idle", busy, 1'b0);
    req_b = 1'b1;
    at_edge(b0 + 1018); req_b = 1'b0;
    check("b2b_accept_pb", pb, 1'b1);
    check("b2b_no_drop", drop, 1'b0);
    at_edge(b0 + 2034); check("b2b_second_done", done, 1'b1);

    // Reset in the middle of a short press
    r0 = 15400;
    at_edge(r0 - 1);    req_b = 1'b1;
    at_edge(r0);        req_b = 1'b0;
    at_edge(r0 + 499);  rst = 1'b0;
    #1;
    check("async_reset_pb", pb, 1'b0);
    check("async_reset_busy", busy, 1'b0);
    at_edge(r0 + 503);  rst = 1'b1;
    at_edge(r0 + 509);  req_a = 1'b1;
    at_edge(r0 + 510);  req_a = 1'b0;
    check("post_reset_accept", pb, 1'b1);
    at_edge(r0 + 510 + 6000); check("post_reset_release", pb, 1'b0);
    at_edge(r0 + 510 + 6016); check("post_reset_done", done, 1'b1);
    at_edge(r0 + 510 + 6020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
